// File: rtl/fht_stream_io_if.sv
// Port bundle of fht_stream_io: sample input, bank RAM write/read ports,
// FHT core handshake and result stream. The master modport is the block side.
interface fht_stream_io_if #(
   parameter int A_BIT = 8,
   parameter int D_BIT = 16
);
   logic             iDATA_VALID;
   logic [D_BIT-1:0] iDATA;
   logic             oDATA_READY;

   logic             oWE;
   logic [1:0]       oWR_BANK;
   logic [A_BIT-1:0] oWR_ADDR;
   logic [D_BIT-1:0] oWR_DATA;

   logic [1:0]       oRD_BANK;
   logic [A_BIT-1:0] oRD_ADDR;
   logic [D_BIT-1:0] iRD_DATA;

   logic             oSTART;
   logic             iCORE_RDY;

   logic             oOUT_VALID;
   logic [D_BIT-1:0] oOUT_DATA;
   logic             oOUT_LAST;
   logic             iOUT_READY;

   logic             oBUSY;

   modport master (
      input  iDATA_VALID, iDATA, iRD_DATA, iCORE_RDY, iOUT_READY,
      output oDATA_READY, oWE, oWR_BANK, oWR_ADDR, oWR_DATA,
      output oRD_BANK, oRD_ADDR, oSTART, oOUT_VALID, oOUT_DATA, oOUT_LAST, oBUSY
   );

   modport slave (
      output iDATA_VALID, iDATA, iRD_DATA, iCORE_RDY, iOUT_READY,
      input  oDATA_READY, oWE, oWR_BANK, oWR_ADDR, oWR_DATA,
      input  oRD_BANK, oRD_ADDR, oSTART, oOUT_VALID, oOUT_DATA, oOUT_LAST, oBUSY
   );
endinterface

// File: rtl/fht_stream_io.sv
// Streaming front/back end of a 4-bank FHT: loads N samples, starts the core,
// then unloads results through a 4-entry FIFO. FHT_IO_BITREV_EN: bit-reversed load order.
module fht_stream_io #(
   parameter int A_BIT = 8,
   parameter int D_BIT = 16
) (
   input  logic            iCLK,
   input  logic            iRESET,
   fht_stream_io_if.master bus
);
   localparam int C_BIT = A_BIT + 2;
   localparam logic [C_BIT-1:0] LAST_IDX = '1;

   typedef enum logic [2:0] {LOAD, START, WAIT_BUSY, WAIT_DONE, UNLOAD} state_t;

   state_t           state_q, state_d;
   logic [C_BIT-1:0] in_cnt_q, in_cnt_d;
   logic [C_BIT-1:0] rd_cnt_q, rd_cnt_d;
   logic             rd_all_q, rd_all_d;
   logic [1:0]       rd_v_q;
   logic [1:0]       rd_last_q;
   logic [1:0]       wr_ptr_q, rd_ptr_q;
   logic [2:0]       fifo_cnt_q;
   logic [D_BIT:0]   fifo_mem [4];

   logic             accept, issue, push, pop, fifo_nempty;
   logic [2:0]       credit_used;
   logic [D_BIT:0]   head;
   logic [C_BIT-1:0] wr_idx;

`ifdef FHT_IO_BITREV_EN
   for (genvar gi = 0; gi < C_BIT; gi++) begin : g_bitrev
      assign wr_idx[gi] = in_cnt_q[C_BIT-1-gi];
   end
`else
   assign wr_idx = in_cnt_q;
`endif

   assign fifo_nempty = (fifo_cnt_q != 3'd0);
   assign head        = fifo_mem[rd_ptr_q];
   assign push        = rd_v_q[1];
   assign pop         = fifo_nempty && bus.iOUT_READY;
   // Reads in flight reserve a FIFO slot, so a full FIFO can never be overrun.
   assign credit_used = fifo_cnt_q + {2'b00, rd_v_q[0]} + {2'b00, rd_v_q[1]};

   always_comb begin
      state_d  = state_q;
      in_cnt_d = in_cnt_q;
      rd_cnt_d = rd_cnt_q;
      rd_all_d = rd_all_q;
      accept   = 1'b0;
      issue    = 1'b0;
      case (state_q)
         LOAD: begin
            if (bus.iDATA_VALID) begin
               accept   = 1'b1;
               in_cnt_d = in_cnt_q + 1'b1;
               if (in_cnt_q == LAST_IDX) begin
                  in_cnt_d = '0;
                  state_d  = START;
               end
            end
         end
         START:     state_d = WAIT_BUSY;
         WAIT_BUSY: if (!bus.iCORE_RDY) state_d = WAIT_DONE;
         WAIT_DONE: if (bus.iCORE_RDY)  state_d = UNLOAD;
         UNLOAD: begin
            if (!rd_all_q && credit_used < 3'd4) begin
               issue    = 1'b1;
               rd_cnt_d = rd_cnt_q + 1'b1;
               if (rd_cnt_q == LAST_IDX) begin
                  rd_cnt_d = '0;
                  rd_all_d = 1'b1;
               end
            end
            if (pop && head[D_BIT]) begin
               state_d  = LOAD;
               rd_cnt_d = '0;
               rd_all_d = 1'b0;
            end
         end
         default: state_d = LOAD;
      endcase
   end

   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         state_q    <= LOAD;
         in_cnt_q   <= '0;
         rd_cnt_q   <= '0;
         rd_all_q   <= 1'b0;
         rd_v_q     <= '0;
         rd_last_q  <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         in_cnt_q  <= in_cnt_d;
         rd_cnt_q  <= rd_cnt_d;
         rd_all_q  <= rd_all_d;
         rd_v_q    <= {rd_v_q[0], issue};
         rd_last_q <= {rd_last_q[0], issue && (rd_cnt_q == LAST_IDX)};
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   fifo_cnt_q <= fifo_cnt_q + 3'd1;
            2'b01:   fifo_cnt_q <= fifo_cnt_q - 3'd1;
            default: fifo_cnt_q <= fifo_cnt_q;
         endcase
      end
   end

   // Payload storage carries no reset; occupancy alone defines what is valid.
   always_ff @(posedge iCLK) begin
      if (push) fifo_mem[wr_ptr_q] <= {rd_last_q[1], bus.iRD_DATA};
   end

   assign bus.oDATA_READY = (state_q == LOAD);
   assign bus.oWE         = accept;
   assign bus.oWR_BANK    = accept ? wr_idx[1:0] : 2'b00;
   assign bus.oWR_ADDR    = accept ? wr_idx[C_BIT-1:2] : '0;
   assign bus.oWR_DATA    = accept ? bus.iDATA : '0;
   assign bus.oRD_BANK    = rd_cnt_q[1:0];
   assign bus.oRD_ADDR    = rd_cnt_q[C_BIT-1:2];
   assign bus.oSTART      = (state_q == START);
   assign bus.oOUT_VALID  = fifo_nempty;
   assign bus.oOUT_DATA   = fifo_nempty ? head[D_BIT-1:0] : '0;
   assign bus.oOUT_LAST   = fifo_nempty && head[D_BIT];
   assign bus.oBUSY       = (state_q != LOAD);
endmodule

// File: tb/tb_fht_stream_io.sv
// Bench for fht_stream_io: random load/unload traffic against a bank RAM model
// and a reference of where each sample lands and in which order results leave.
module tb_fht_stream_io;
   localparam int A_BIT = 8;
   localparam int D_BIT = 16;
   localparam int N     = 4 << A_BIT;

   logic iCLK;
   logic iRESET;

   fht_stream_io_if #(.A_BIT(A_BIT), .D_BIT(D_BIT)) bus();

   fht_stream_io #(.A_BIT(A_BIT), .D_BIT(D_BIT)) dut (
      .iCLK   (iCLK),
      .iRESET (iRESET),
      .bus    (bus)
   );

   initial begin
      iCLK = 1'b0;
      forever #5 iCLK = ~iCLK;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
      end
   endtask

   // Storage index of load sample n: natural, or reversed over A_BIT+2 bits.
   function automatic int map_idx(input int n);
      int r;
      r = n;
`ifdef FHT_IO_BITREV_EN
      r = 0;
      for (int b = 0; b < A_BIT + 2; b++)
         if (((n >> b) & 1) != 0) r = r | (1 << (A_BIT + 1 - b));
`endif
      return r;
   endfunction

   logic [D_BIT-1:0] samp    [N];
   logic [D_BIT-1:0] exp_out [N];

   // Bank RAM: flat index {addr, bank}, two-cycle read latency.
   logic [D_BIT-1:0] ram [N];
   logic [D_BIT-1:0] rd_p0, rd_p1;
   always @(posedge iCLK) begin
      if (bus.oWE) ram[{bus.oWR_ADDR, bus.oWR_BANK}] <= bus.oWR_DATA;
      rd_p0 <= ram[{bus.oRD_ADDR, bus.oRD_BANK}];
      rd_p1 <= rd_p0;
   end
   assign bus.iRD_DATA = rd_p1;

   // Transaction monitor, sampled on the falling edge.
   int wr_n       = 0;
   int out_k      = 0;
   int loads_done = 0;
   int units_done = 0;
   int start_cnt  = 0;
   always @(negedge iCLK) begin
      int m;
      if (!iRESET) begin
         wr_n  = 0;
         out_k = 0;
      end else begin
         if (bus.oSTART) start_cnt++;
         if (bus.oWE) begin
            m = map_idx(wr_n);
            check("wr_needs_valid", 32'(bus.iDATA_VALID), 1);
            check("wr_bank", 32'(bus.oWR_BANK), 32'(m % 4));
            check("wr_addr", 32'(bus.oWR_ADDR), 32'(m / 4));
            check("wr_data", 32'(bus.oWR_DATA), 32'(samp[wr_n]));
            if (wr_n == N - 1) begin
               wr_n = 0;
               loads_done++;
            end else begin
               wr_n++;
            end
         end
         if (bus.oOUT_VALID && bus.iOUT_READY) begin
            check("out_data", 32'(bus.oOUT_DATA), 32'(exp_out[out_k]));
            check("out_last", 32'(bus.oOUT_LAST), 32'(out_k == N - 1));
            if (out_k == N - 1) begin
               out_k = 0;
               units_done++;
            end else begin
               out_k++;
            end
         end
      end
   end

   // Sink: random 50% ready, plus one 20-cycle stall once 100 words have left.
   initial begin
      int stall_left;
      bit stall_done;
      int issued;
      stall_left = 0;
      stall_done = 0;
      bus.iOUT_READY = 1'b0;
      forever begin
         @(posedge iCLK);
         #1;
         if (stall_left > 0) begin
            bus.iOUT_READY = 1'b0;
            stall_left--;
            if (stall_left == 0) begin
               issued = int'({bus.oRD_ADDR, bus.oRD_BANK});
               check("stall_outstanding_le4", 32'((issued - out_k) <= 4 && (issued - out_k) >= 0), 1);
               check("stall_holds_data", 32'(bus.oOUT_VALID), 1);
            end
         end else if (!stall_done && out_k >= 100) begin
            stall_done = 1;
            stall_left = 19;
            bus.iOUT_READY = 1'b0;
         end else begin
            bus.iOUT_READY = 1'($urandom_range(0, 1));
         end
      end
   end

   int sc0;

   task automatic run_load(input bit rand_data);
      int ld0;
      int cyc;
      for (int n = 0; n < N; n++) samp[n] = rand_data ? D_BIT'($urandom_range(0, 65535)) : D_BIT'(n);
      for (int n = 0; n < N; n++) exp_out[map_idx(n)] = samp[n];
      ld0 = loads_done;
      sc0 = start_cnt;
      cyc = 0;
      while (loads_done == ld0 && cyc < 8 * N) begin
         @(posedge iCLK);
         #1;
         bus.iDATA_VALID = ($urandom_range(0, 3) != 0);
         bus.iDATA       = samp[wr_n];
         @(negedge iCLK);
         cyc++;
      end
      bus.iDATA_VALID = 1'b0;
      check("load_complete", 32'(loads_done), 32'(ld0 + 1));
      @(posedge iCLK);
      #1;
      check("ready_low_after_load", 32'(bus.oDATA_READY), 0);
      check("busy_after_load", 32'(bus.oBUSY), 1);
   endtask

   task automatic run_core(input bit long_seq);
      int cyc;
      bit seen;
      int lat;
      cyc = 0;
      while (start_cnt == sc0 && cyc < 20) begin
         @(negedge iCLK);
         cyc++;
      end
      check("start_seen", 32'(start_cnt), 32'(sc0 + 1));
      if (long_seq) begin
         seen = 0;
         repeat (5) begin
            @(negedge iCLK);
            if (bus.oOUT_VALID) seen = 1;
         end
         @(posedge iCLK);
         #1;
         bus.iCORE_RDY = 1'b0;
         repeat (300) begin
            @(negedge iCLK);
            if (bus.oOUT_VALID) seen = 1;
         end
         check("no_output_while_core_runs", 32'(seen), 0);
         check("single_start_pulse", 32'(start_cnt), 32'(sc0 + 1));
         @(posedge iCLK);
         #1;
         bus.iCORE_RDY = 1'b1;
         lat = 0;
         while (!bus.oOUT_VALID && lat < 50) begin
            @(negedge iCLK);
            lat++;
         end
         check("first_result_latency", 32'(lat >= 4 && lat <= 8), 1);
      end else begin
         repeat (2) @(posedge iCLK);
         #1;
         bus.iCORE_RDY = 1'b0;
         repeat (10) @(posedge iCLK);
         #1;
         bus.iCORE_RDY = 1'b1;
         check("single_start_pulse", 32'(start_cnt), 32'(sc0 + 1));
      end
   endtask

   task automatic run_unload(input int abort_k);
      int ud0;
      int cyc;
      ud0 = units_done;
      cyc = 0;
      if (abort_k < 0) begin
         while (units_done == ud0 && cyc < 20000) begin
            @(negedge iCLK);
            cyc++;
         end
         check("unload_complete", 32'(units_done), 32'(ud0 + 1));
         @(posedge iCLK);
         #1;
         check("ready_after_unload", 32'(bus.oDATA_READY), 1);
         check("idle_after_unload", 32'(bus.oBUSY), 0);
         check("no_valid_after_unload", 32'(bus.oOUT_VALID), 0);
      end else begin
         while (out_k < abort_k && cyc < 20000) begin
            @(negedge iCLK);
            cyc++;
         end
         check("abort_point_reached", 32'(out_k >= abort_k), 1);
         iRESET = 1'b0;
         #1;
         check("reset_valid_low", 32'(bus.oOUT_VALID), 0);
         check("reset_busy_low", 32'(bus.oBUSY), 0);
         check("reset_last_low", 32'(bus.oOUT_LAST), 0);
         check("reset_start_low", 32'(bus.oSTART), 0);
         repeat (2) @(posedge iCLK);
         @(negedge iCLK);
         iRESET = 1'b1;
         @(posedge iCLK);
         #1;
         check("ready_after_midreset", 32'(bus.oDATA_READY), 1);
      end
   endtask

   initial begin
      bus.iDATA_VALID = 1'b0;
      bus.iDATA       = '0;
      bus.iCORE_RDY   = 1'b1;
      iRESET          = 1'b0;
      repeat (3) @(posedge iCLK);
      #1;
      check("rst_out_valid", 32'(bus.oOUT_VALID), 0);
      check("rst_busy", 32'(bus.oBUSY), 0);
      check("rst_we", 32'(bus.oWE), 0);
      check("rst_start", 32'(bus.oSTART), 0);
      check("rst_last", 32'(bus.oOUT_LAST), 0);
      check("rst_rd_addr", 32'({bus.oRD_ADDR, bus.oRD_BANK}), 0);
      check("rst_wr_addr", 32'({bus.oWR_ADDR, bus.oWR_BANK}), 0);
      check("rst_out_data", 32'(bus.oOUT_DATA), 0);
      @(negedge iCLK);
      iRESET = 1'b1;
      @(posedge iCLK);
      #1;
      check("ready_after_reset", 32'(bus.oDATA_READY), 1);

      run_load(1'b0);
      run_core(1'b1);
      run_unload(-1);

      run_load(1'b1);
      run_core(1'b0);
      run_unload(300);

      run_load(1'b1);
      run_core(1'b0);
      run_unload(-1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
